// File: rtl/hbm_mem_driver.sv
// HBM stack stand-in: per pseudo-channel AXI slaves backed by a zero-initialised word store,
// with a calibration delay on the user reset.
module hbm_mem_driver #(
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned CAL_CYCLES = 16
) (
  input  logic                      sys_clk_100M,
  input  logic                      sys_rstn,
  output logic                      hbm_clk,
  output logic                      hbm_rstn,
  input  logic [NUM_CH-1:0][32:0]   hbm_axi_awaddr,
  input  logic [NUM_CH-1:0][5:0]    hbm_axi_awid,
  input  logic [NUM_CH-1:0][3:0]    hbm_axi_awlen,
  input  logic [NUM_CH-1:0][2:0]    hbm_axi_awsize,
  input  logic [NUM_CH-1:0][1:0]    hbm_axi_awburst,
  input  logic [NUM_CH-1:0]         hbm_axi_awvalid,
  output logic [NUM_CH-1:0]         hbm_axi_awready,
  input  logic [NUM_CH-1:0][255:0]  hbm_axi_wdata,
  input  logic [NUM_CH-1:0][31:0]   hbm_axi_wstrb,
  input  logic [NUM_CH-1:0]         hbm_axi_wlast,
  input  logic [NUM_CH-1:0]         hbm_axi_wvalid,
  output logic [NUM_CH-1:0]         hbm_axi_wready,
  output logic [NUM_CH-1:0][5:0]    hbm_axi_bid,
  output logic [NUM_CH-1:0][1:0]    hbm_axi_bresp,
  output logic [NUM_CH-1:0]         hbm_axi_bvalid,
  input  logic [NUM_CH-1:0]         hbm_axi_bready,
  input  logic [NUM_CH-1:0][32:0]   hbm_axi_araddr,
  input  logic [NUM_CH-1:0][5:0]    hbm_axi_arid,
  input  logic [NUM_CH-1:0][3:0]    hbm_axi_arlen,
  input  logic [NUM_CH-1:0][2:0]    hbm_axi_arsize,
  input  logic [NUM_CH-1:0][1:0]    hbm_axi_arburst,
  input  logic [NUM_CH-1:0]         hbm_axi_arvalid,
  output logic [NUM_CH-1:0]         hbm_axi_arready,
  output logic [NUM_CH-1:0][255:0]  hbm_axi_rdata,
  output logic [NUM_CH-1:0][5:0]    hbm_axi_rid,
  output logic [NUM_CH-1:0][1:0]    hbm_axi_rresp,
  output logic [NUM_CH-1:0]         hbm_axi_rlast,
  output logic [NUM_CH-1:0]         hbm_axi_rvalid,
  input  logic [NUM_CH-1:0]         hbm_axi_rready
);

  localparam int unsigned IW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = $clog2(CAL_CYCLES + 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [CW-1:0] cal_cnt;
  logic          unused_bits;

  assign hbm_clk     = sys_clk_100M;
  assign unused_bits = ^{hbm_axi_awsize, hbm_axi_awburst, hbm_axi_arsize, hbm_axi_arburst,
                         hbm_axi_awaddr, hbm_axi_araddr};

  // Calibration delay: user reset releases on the edge the counter reaches CAL_CYCLES.
  always_ff @(posedge sys_clk_100M or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cal_cnt  <= '0;
      hbm_rstn <= 1'b0;
    end else if (!hbm_rstn) begin
      cal_cnt <= cal_cnt + CW'(1);
      if (cal_cnt == CW'(CAL_CYCLES - 1)) hbm_rstn <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [255:0] mem [MEM_DEPTH] = '{default: '0};

    w_state_t     w_state, w_state_nxt;
    logic [IW-1:0] w_idx;
    logic [3:0]   w_len, w_beat;
    logic [5:0]   w_id;
    logic         w_ok;
    logic         aw_rdy, w_rdy, b_vld;
    logic [5:0]   b_id;
    logic [1:0]   b_resp;
    logic         aw_fire, w_fire, b_fire;

    r_state_t     r_state, r_state_nxt;
    logic [IW-1:0] r_idx, a_idx;
    logic [3:0]   r_len, r_beat;
    logic [5:0]   r_id;
    logic [255:0] r_data;
    logic         ar_rdy, r_vld, r_lst;
    logic [5:0]   r_id_o;
    logic [255:0] r_dat;
    logic         ar_fire, r_fire;

    assign aw_fire = hbm_axi_awvalid[c] & aw_rdy;
    assign w_fire  = hbm_axi_wvalid[c]  & w_rdy;
    assign b_fire  = hbm_axi_bready[c]  & b_vld;
    assign ar_fire = hbm_axi_arvalid[c] & ar_rdy;
    assign r_fire  = hbm_axi_rready[c]  & r_vld;
    assign a_idx   = hbm_axi_araddr[c][5 +: IW];

    always_ff @(posedge sys_clk_100M or negedge sys_rstn) begin
      if (!sys_rstn) w_state <= W_IDLE;
      else           w_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = w_state;
      case (w_state)
        W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
        W_DATA:  if (w_fire && (w_beat == w_len)) w_state_nxt = W_RESP;
        W_RESP:  if (b_fire) w_state_nxt = W_IDLE;
        default: w_state_nxt = W_IDLE;
      endcase
    end

    always_comb begin
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      b_vld  = 1'b0;
      b_id   = '0;
      b_resp = '0;
      if (hbm_rstn) begin
        case (w_state)
          W_IDLE: aw_rdy = 1'b1;
          W_DATA: w_rdy  = 1'b1;
          W_RESP: begin
            b_vld  = 1'b1;
            b_id   = w_id;
            b_resp = w_ok ? 2'b00 : 2'b10;
          end
          default: ;
        endcase
      end
    end

    // w_ok tracks that wlast appeared on the final beat and nowhere else.
    always_ff @(posedge sys_clk_100M or negedge sys_rstn) begin
      if (!sys_rstn) begin
        w_idx  <= '0;
        w_len  <= '0;
        w_beat <= '0;
        w_id   <= '0;
        w_ok   <= 1'b0;
      end else if (aw_fire) begin
        w_idx  <= hbm_axi_awaddr[c][5 +: IW];
        w_len  <= hbm_axi_awlen[c];
        w_beat <= '0;
        w_id   <= hbm_axi_awid[c];
        w_ok   <= 1'b1;
      end else if (w_fire) begin
        w_idx  <= w_idx + IW'(1);
        w_beat <= w_beat + 4'd1;
        w_ok   <= w_ok & (hbm_axi_wlast[c] == (w_beat == w_len));
      end
    end

    always_ff @(posedge sys_clk_100M) begin
      for (int b = 0; b < 32; b++) begin
        if (w_fire && hbm_axi_wstrb[c][b]) mem[w_idx][8*b +: 8] <= hbm_axi_wdata[c][8*b +: 8];
      end
    end

    always_ff @(posedge sys_clk_100M or negedge sys_rstn) begin
      if (!sys_rstn) r_state <= R_IDLE;
      else           r_state <= r_state_nxt;
    end

    always_comb begin
      r_state_nxt = r_state;
      case (r_state)
        R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
        R_DATA:  if (r_fire && (r_beat == r_len)) r_state_nxt = R_IDLE;
        default: r_state_nxt = R_IDLE;
      endcase
    end

    always_comb begin
      ar_rdy = 1'b0;
      r_vld  = 1'b0;
      r_dat  = '0;
      r_id_o = '0;
      r_lst  = 1'b0;
      if (hbm_rstn) begin
        case (r_state)
          R_IDLE: ar_rdy = 1'b1;
          R_DATA: begin
            r_vld  = 1'b1;
            r_dat  = r_data;
            r_id_o = r_id;
            r_lst  = (r_beat == r_len);
          end
          default: ;
        endcase
      end
    end

    // Read data is fetched one beat ahead into r_data so it holds during stalls and is read-first.
    always_ff @(posedge sys_clk_100M or negedge sys_rstn) begin
      if (!sys_rstn) begin
        r_idx  <= '0;
        r_len  <= '0;
        r_beat <= '0;
        r_id   <= '0;
        r_data <= '0;
      end else if (ar_fire) begin
        r_idx  <= a_idx;
        r_len  <= hbm_axi_arlen[c];
        r_beat <= '0;
        r_id   <= hbm_axi_arid[c];
        r_data <= mem[a_idx];
      end else if (r_fire && (r_beat != r_len)) begin
        r_idx  <= r_idx + IW'(1);
        r_beat <= r_beat + 4'd1;
        r_data <= mem[r_idx + IW'(1)];
      end
    end

    assign hbm_axi_awready[c] = aw_rdy;
    assign hbm_axi_wready[c]  = w_rdy;
    assign hbm_axi_bvalid[c]  = b_vld;
    assign hbm_axi_bid[c]     = b_id;
    assign hbm_axi_bresp[c]   = b_resp;
    assign hbm_axi_arready[c] = ar_rdy;
    assign hbm_axi_rvalid[c]  = r_vld;
    assign hbm_axi_rdata[c]   = r_dat;
    assign hbm_axi_rid[c]     = r_id_o;
    assign hbm_axi_rresp[c]   = 2'b00;
    assign hbm_axi_rlast[c]   = r_lst;
  end

endmodule

// File: tb/tb_hbm_mem_driver.sv
// Scoreboard bench for hbm_mem_driver: calibration reset, bursts, strobes, stalls, wrap, abort.
module tb_hbm_mem_driver;

  localparam int unsigned NUM_CH     = 32;
  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned CAL_CYCLES = 16;
  localparam int unsigned IW         = $clog2(MEM_DEPTH);
  localparam int          TMO        = 100;

  logic sys_clk_100M = 1'b0;
  logic sys_rstn     = 1'b0;
  logic hbm_clk, hbm_rstn;

  logic [NUM_CH-1:0][32:0]  awaddr, araddr;
  logic [NUM_CH-1:0][5:0]   awid, arid, bid, rid;
  logic [NUM_CH-1:0][3:0]   awlen, arlen;
  logic [NUM_CH-1:0][2:0]   awsize, arsize;
  logic [NUM_CH-1:0][1:0]   awburst, arburst, bresp, rresp;
  logic [NUM_CH-1:0]        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [NUM_CH-1:0]        arvalid, arready, rlast, rvalid, rready;
  logic [NUM_CH-1:0][255:0] wdata, rdata;
  logic [NUM_CH-1:0][31:0]  wstrb;

  typedef struct packed { logic [255:0] data; logic last; logic [5:0] id; } rexp_t;
  typedef struct packed { logic [5:0] id; logic [1:0] resp; } bexp_t;

  rexp_t        rq[$];
  bexp_t        bq[$];
  logic [255:0] model [int];
  logic [255:0] wbeat [16];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 sys_clk_100M = ~sys_clk_100M;

  hbm_mem_driver #(.NUM_CH(NUM_CH), .MEM_DEPTH(MEM_DEPTH), .CAL_CYCLES(CAL_CYCLES)) dut (
    .sys_clk_100M(sys_clk_100M), .sys_rstn(sys_rstn), .hbm_clk(hbm_clk), .hbm_rstn(hbm_rstn),
    .hbm_axi_awaddr(awaddr), .hbm_axi_awid(awid), .hbm_axi_awlen(awlen), .hbm_axi_awsize(awsize),
    .hbm_axi_awburst(awburst), .hbm_axi_awvalid(awvalid), .hbm_axi_awready(awready),
    .hbm_axi_wdata(wdata), .hbm_axi_wstrb(wstrb), .hbm_axi_wlast(wlast), .hbm_axi_wvalid(wvalid),
    .hbm_axi_wready(wready), .hbm_axi_bid(bid), .hbm_axi_bresp(bresp), .hbm_axi_bvalid(bvalid),
    .hbm_axi_bready(bready), .hbm_axi_araddr(araddr), .hbm_axi_arid(arid), .hbm_axi_arlen(arlen),
    .hbm_axi_arsize(arsize), .hbm_axi_arburst(arburst), .hbm_axi_arvalid(arvalid),
    .hbm_axi_arready(arready), .hbm_axi_rdata(rdata), .hbm_axi_rid(rid), .hbm_axi_rresp(rresp),
    .hbm_axi_rlast(rlast), .hbm_axi_rvalid(rvalid), .hbm_axi_rready(rready)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mget(input int ch, input int idx);
    int key = ch * int'(MEM_DEPTH) + idx;
    return model.exists(key) ? model[key] : '0;
  endfunction

  function automatic void mput(input int ch, input int idx, input logic [255:0] d,
                               input logic [31:0] s);
    logic [255:0] v = mget(ch, idx);
    for (int b = 0; b < 32; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    model[ch * int'(MEM_DEPTH) + idx] = v;
  endfunction

  task automatic cal_release();
    @(negedge sys_clk_100M);
    sys_rstn = 1'b1;
    for (int k = 1; k <= int'(CAL_CYCLES) + 1; k++) begin
      @(posedge sys_clk_100M); #1;
      check("hbm_clk_hi", 256'(hbm_clk), 256'(1));
      check("hbm_rstn", 256'(hbm_rstn), 256'(k >= int'(CAL_CYCLES)));
      if (k < int'(CAL_CYCLES)) check("cal_rdy", 256'({awready[0], arready[0], wready[0]}), 256'(0));
      @(negedge sys_clk_100M); #1;
      check("hbm_clk_lo", 256'(hbm_clk), 256'(0));
    end
  endtask

  task automatic do_aw(input int ch, input logic [32:0] a, input logic [5:0] id, input logic [3:0] len);
    @(negedge sys_clk_100M);
    awaddr[ch] = a; awid[ch] = id; awlen[ch] = len; awsize[ch] = 3'd5; awburst[ch] = 2'b01;
    awvalid[ch] = 1'b1;
    for (int n = 0; n < TMO && !awready[ch]; n++) @(negedge sys_clk_100M);
    check("aw_ready", 256'(awready[ch]), 256'(1));
    @(posedge sys_clk_100M); #1;
    awvalid[ch] = 1'b0;
  endtask

  task automatic do_w(input int ch, input logic [255:0] d, input logic [31:0] s, input logic last);
    @(negedge sys_clk_100M);
    wdata[ch] = d; wstrb[ch] = s; wlast[ch] = last; wvalid[ch] = 1'b1;
    for (int n = 0; n < TMO && !wready[ch]; n++) @(negedge sys_clk_100M);
    check("w_ready", 256'(wready[ch]), 256'(1));
    @(posedge sys_clk_100M); #1;
    wvalid[ch] = 1'b0;
  endtask

  task automatic do_b(input int ch);
    bexp_t e;
    @(negedge sys_clk_100M);
    bready[ch] = 1'b1;
    for (int n = 0; n < TMO && !bvalid[ch]; n++) @(negedge sys_clk_100M);
    check("b_valid", 256'(bvalid[ch]), 256'(1));
    e = bq.pop_front();
    check("bid", 256'(bid[ch]), 256'(e.id));
    check("bresp", 256'(bresp[ch]), 256'(e.resp));
    @(posedge sys_clk_100M); #1;
    bready[ch] = 1'b0;
    @(negedge sys_clk_100M);
    check("b_done", 256'({bvalid[ch], bid[ch], bresp[ch]}), 256'(0));
  endtask

  task automatic axi_write(input int ch, input logic [32:0] a, input logic [5:0] id,
                           input logic [3:0] len, input logic [31:0] s, input int last_beat);
    int idx = int'(a[5 +: IW]);
    bexp_t e;
    e.id = id;
    e.resp = (last_beat == int'(len)) ? 2'b00 : 2'b10;
    bq.push_back(e);
    do_aw(ch, a, id, len);
    for (int b = 0; b <= int'(len); b++) begin
      do_w(ch, wbeat[b], s, b == last_beat);
      mput(ch, idx, wbeat[b], s);
      idx = (idx + 1) % int'(MEM_DEPTH);
    end
    do_b(ch);
  endtask

  task automatic axi_read(input int ch, input logic [32:0] a, input logic [5:0] id,
                          input logic [3:0] len, input bit toggle);
    int idx = int'(a[5 +: IW]);
    int beats = 0;
    rexp_t e;
    for (int b = 0; b <= int'(len); b++) begin
      e.data = mget(ch, idx); e.last = (b == int'(len)); e.id = id;
      rq.push_back(e);
      idx = (idx + 1) % int'(MEM_DEPTH);
    end
    @(negedge sys_clk_100M);
    araddr[ch] = a; arid[ch] = id; arlen[ch] = len; arsize[ch] = 3'd5; arburst[ch] = 2'b01;
    arvalid[ch] = 1'b1;
    for (int n = 0; n < TMO && !arready[ch]; n++) @(negedge sys_clk_100M);
    check("ar_ready", 256'(arready[ch]), 256'(1));
    @(posedge sys_clk_100M); #1;
    arvalid[ch] = 1'b0;
    for (int cyc = 0; cyc < TMO && beats <= int'(len); cyc++) begin
      @(negedge sys_clk_100M);
      rready[ch] = toggle ? (cyc % 2 == 0) : 1'b1;
      check("r_valid", 256'(rvalid[ch]), 256'(1));
      check("rdata", rdata[ch], rq[0].data);
      check("rlast", 256'(rlast[ch]), 256'(rq[0].last));
      check("rid_rresp", 256'({rid[ch], rresp[ch]}), 256'({rq[0].id, 2'b00}));
      if (rvalid[ch] && rready[ch]) begin
        void'(rq.pop_front());
        beats++;
      end
    end
    @(negedge sys_clk_100M);
    rready[ch] = 1'b0;
    check("r_beats", 256'(beats), 256'(int'(len) + 1));
    check("r_idle", 256'({rvalid[ch], rlast[ch], rdata[ch]}), 256'(0));
  endtask

  initial begin
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = '0;
    wdata = '0; wstrb = '0; wlast = '0; wvalid = '0; bready = '0;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = '0; rready = '0;

    repeat (2) @(posedge sys_clk_100M);
    #1;
    check("rst_hbm_rstn", 256'(hbm_rstn), 256'(0));
    check("rst_ready", 256'({awready, arready, wready}), 256'(0));
    check("rst_valid", 256'({bvalid, rvalid}), 256'(0));
    cal_release();

    // Four-beat burst on ch0, then read it back.
    for (int b = 0; b < 4; b++) wbeat[b] = 256'(b + 1);
    axi_write(0, 33'h40, 6'h2a, 4'd3, '1, 3);
    axi_read(0, 33'h40, 6'h15, 4'd3, 1'b0);

    // Partial strobe on ch8; ch0 word 0 untouched.
    wbeat[0] = '1;
    axi_write(8, 33'h0, 6'h08, 4'd0, 32'h0000_000F, 0);
    axi_read(8, 33'h0, 6'h01, 4'd0, 1'b0);
    check("ch8_low4", mget(8, 0), 256'hFFFF_FFFF);
    axi_read(0, 33'h0, 6'h02, 4'd0, 1'b0);

    // Stalled read with rready 1-0-1-0.
    axi_read(0, 33'h40, 6'h33, 4'd1, 1'b1);

    // Early wlast -> SLVERR, both beats still land.
    wbeat[0] = 256'hAAAA_0001; wbeat[1] = 256'hBBBB_0002;
    axi_write(1, 33'h100, 6'h11, 4'd1, '1, 0);
    axi_read(1, 33'h100, 6'h12, 4'd1, 1'b0);

    // Burst across the top of the store wraps to word 0.
    wbeat[0] = 256'hBEEF; wbeat[1] = 256'hCAFE;
    axi_write(2, 33'((MEM_DEPTH - 1) * 32), 6'h21, 4'd1, '1, 1);
    axi_read(2, 33'h0, 6'h22, 4'd0, 1'b0);
    axi_read(2, 33'((MEM_DEPTH - 1) * 32), 6'h23, 4'd1, 1'b0);

    // Reset mid-burst: two committed beats survive, outputs drop at once.
    do_aw(3, 33'h0, 6'h05, 4'd3);
    do_w(3, 256'hA1, '1, 1'b0); mput(3, 0, 256'hA1, '1);
    do_w(3, 256'hA2, '1, 1'b0); mput(3, 1, 256'hA2, '1);
    @(negedge sys_clk_100M);
    wvalid[3] = 1'b1;
    check("pre_abort_wready", 256'(wready[3]), 256'(1));
    sys_rstn = 1'b0;
    #1;
    check("abort_hbm_rstn", 256'(hbm_rstn), 256'(0));
    check("abort_ready", 256'({awready[3], wready[3], arready[3]}), 256'(0));
    wvalid[3] = 1'b0;
    cal_release();
    axi_read(3, 33'h0, 6'h06, 4'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
